// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: scans latched operands MSB first, one bit per
// clock, and reports a registered one-hot gt/eq/lt result with a done pulse.
module serial_mag_comparator #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned      IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             dec_gt;

  logic bit_a;
  logic bit_b;
  logic bit_diff;
  logic a_wins;
  logic last_bit;
  logic finish;

  // When the bits differ, ~bit_a equals bit_b, so the sign bit's inverted sense
  // reduces to taking B's bit.
  always_comb begin
    bit_a    = a_q[idx];
    bit_b    = b_q[idx];
    bit_diff = bit_a ^ bit_b;
    a_wins   = (signed_q && (idx == IDX_MSB)) ? bit_b : bit_a;
    last_bit = (idx == '0);
    finish   = last_bit || ((EARLY_EXIT != 0) && bit_diff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first difference is held in decided/dec_gt so a fixed-latency scan
  // keeps it while walking the remaining lower bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= '0;
      decided  <= 1'b0;
      dec_gt   <= 1'b0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx      <= IDX_MSB;
            decided  <= 1'b0;
            dec_gt   <= 1'b0;
          end
        end
        SCAN: begin
          if (!last_bit) idx <= idx - IDX_W'(1);
          if (bit_diff && !decided) begin
            decided <= 1'b1;
            dec_gt  <= a_wins;
          end
          if (finish) begin
            gt <= decided ? dec_gt  : (bit_diff & a_wins);
            lt <= decided ? ~dec_gt : (bit_diff & ~a_wins);
            eq <= ~decided & ~bit_diff;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: early-exit and fixed-latency instances share
// stimulus; an arithmetic model predicts every cycle, literals pin key cases.
module tb_serial_mag_comparator;

  localparam int unsigned W  = 8;
  localparam logic [2:0]  GT = 3'b100;
  localparam logic [2:0]  EQ = 3'b010;
  localparam logic [2:0]  LT = 3'b001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy_e, done_e, gt_e, eq_e, lt_e;
  logic         busy_f, done_f, gt_f, eq_f, lt_f;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy_e), .done(done_e),
    .gt(gt_e), .eq(eq_e), .lt(lt_e)
  );

  serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy_f), .done(done_f),
    .gt(gt_f), .eq(eq_f), .lt(lt_f)
  );

  int         nvec = 0;
  int         nerr = 0;
  int         pos[2];
  int         lat[2];
  logic [2:0] res[2];
  logic [2:0] pend[2];
  bit         lit_v[2];
  bit         lit_set[2];
  int         lit_cyc[2];
  logic [2:0] lit_res[2];

  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input bit early);
    int j;
    bit same;
    j    = 0;
    same = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (same && (x[i] == y[i])) j++;
      else same = 1'b0;
    end
    return (early && (j < W)) ? j + 2 : W + 1;
  endfunction

  function automatic logic [2:0] model_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sm);
    int sx;
    int sy;
    if (sm) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'({24'd0, x});
      sy = int'({24'd0, y});
    end
    if (sx > sy)  return GT;
    if (sx == sy) return EQ;
    return LT;
  endfunction

  task automatic model_update(input logic st, input logic [W-1:0] ia, input logic [W-1:0] ib,
                              input logic sm, input logic rn);
    for (int d = 0; d < 2; d++) begin
      if (!rn) begin
        pos[d] = 0;
        res[d] = 3'b000;
      end else if (pos[d] == 0) begin
        if (st) begin
          pos[d]  = 1;
          lat[d]  = model_lat(ia, ib, d == 0);
          pend[d] = model_cmp(ia, ib, sm);
        end
      end else if (pos[d] == lat[d]) begin
        pos[d] = 0;
      end else begin
        pos[d]++;
        if (pos[d] == lat[d]) res[d] = pend[d];
      end
    end
  endtask

  task automatic check_cycle();
    logic [4:0] got[2];
    logic [4:0] exp;
    got[0] = {busy_e, done_e, gt_e, eq_e, lt_e};
    got[1] = {busy_f, done_f, gt_f, eq_f, lt_f};
    for (int d = 0; d < 2; d++) begin
      exp = {pos[d] != 0, (pos[d] != 0) && (pos[d] == lat[d]), res[d]};
      nvec++;
      if (got[d] !== exp) begin
        nerr++;
        $display("FAIL cycle_%s t=%0t busy/done/gt/eq/lt got=%b exp=%b",
                 d == 0 ? "early" : "fixed", $time, got[d], exp);
      end
      if (got[d][3] && lit_v[d]) begin
        nvec++;
        if ((pos[d] != lit_cyc[d]) || (got[d][2:0] !== lit_res[d])) begin
          nerr++;
          $display("FAIL literal_%s done_cycle got=%0d exp=%0d result got=%b exp=%b",
                   d == 0 ? "early" : "fixed", pos[d], lit_cyc[d], got[d][2:0], lit_res[d]);
        end
        lit_v[d] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic st, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic sm, input logic rn);
    start       = st;
    a           = ia;
    b           = ib;
    signed_mode = sm;
    rst_n       = rn;
    @(posedge clk);
    model_update(st, ia, ib, sm, rn);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle_step();
    step(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic set_lit(input int ecyc, input logic [2:0] eres,
                         input int fcyc, input logic [2:0] fres);
    lit_v[0]   = (ecyc != 0);
    lit_set[0] = (ecyc != 0);
    lit_cyc[0] = ecyc;
    lit_res[0] = eres;
    lit_v[1]   = (fcyc != 0);
    lit_set[1] = (fcyc != 0);
    lit_cyc[1] = fcyc;
    lit_res[1] = fres;
  endtask

  task automatic lit_consumed();
    for (int d = 0; d < 2; d++) begin
      if (lit_set[d]) begin
        nvec++;
        if (lit_v[d]) begin
          nerr++;
          $display("FAIL no_done_%s expected done at cycle %0d, done pulse missing",
                   d == 0 ? "early" : "fixed", lit_cyc[d]);
        end
      end
      lit_set[d] = 1'b0;
      lit_v[d]   = 1'b0;
    end
  endtask

  task automatic check_zero(input string name);
    nvec++;
    if ({busy_e, done_e, gt_e, eq_e, lt_e} !== 5'b0) begin
      nerr++;
      $display("FAIL %s busy/done/gt/eq/lt got=%b exp=00000", name,
               {busy_e, done_e, gt_e, eq_e, lt_e});
    end
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm,
                    input int ecyc, input logic [2:0] eres,
                    input int fcyc, input logic [2:0] fres, input int n);
    set_lit(ecyc, eres, fcyc, fres);
    step(1'b1, ia, ib, sm, 1'b1);
    for (int k = 1; k < n; k++) idle_step();
    lit_consumed();
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    for (int d = 0; d < 2; d++) begin
      pos[d]     = 0;
      lat[d]     = 0;
      res[d]     = 3'b000;
      pend[d]    = 3'b000;
      lit_v[d]   = 1'b0;
      lit_set[d] = 1'b0;
    end

    // Reset with start held high: start must be ignored.
    step(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b0);
    check_zero("reset_state");
    step(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b0);
    idle_step();
    check_zero("idle_after_reset");

    op(8'hA5, 8'h5A, 1'b0, 2, GT, 9, GT, 10);
    op(8'h80, 8'h01, 1'b1, 2, LT, 9, LT, 10);
    op(8'h80, 8'h01, 1'b0, 2, GT, 9, GT, 10);
    op(8'h13, 8'h12, 1'b0, 9, GT, 9, GT, 10);
    op(8'h13, 8'h11, 1'b0, 8, GT, 9, GT, 10);
    op(8'h3C, 8'h3C, 1'b1, 9, EQ, 9, EQ, 10);
    op(8'hFF, 8'h7F, 1'b1, 2, LT, 9, LT, 10);
    op(8'h7E, 8'h7F, 1'b1, 9, LT, 9, LT, 10);

    // Starts while busy carry operands that would flip the result.
    set_lit(4, LT, 9, LT);
    step(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) idle_step();
    lit_consumed();

    // Reset on the cycle the early instance would commit its decision.
    step(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
    idle_step();
    idle_step();
    step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    check_zero("abort_by_reset");
    for (int k = 0; k < 6; k++) idle_step();
    check_zero("after_abort");

    // Back-to-back: second start in the first IDLE cycle after the early done.
    op(8'h01, 8'h02, 1'b0, 8, LT, 9, LT, 9);
    op(8'h40, 8'h3F, 1'b0, 3, GT, 0, 3'b000, 10);

    for (int r = 0; r < 24; r++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      op(ra, rb, 1'($urandom), 0, 3'b000, 0, 3'b000, 10 + int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
